// File: rtl/uart_pkg.sv
`default_nettype none
//==============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the receiver and the transmitter.
//               Contains the oversample factor, the sample point, the receiver
//               state encodings and the baud-rate/divisor helper functions.
// Revision    : 1.0 - initial release
//==============================================================================
package uart_pkg;

    // 16x oversampling; a bit is sampled on the 8th tick of its window (centre)
    localparam int unsigned c_oversample   = 16;
    localparam int unsigned c_sample_point = 8;

    // Receiver state encodings
    localparam int unsigned c_state_w      = 3;
    localparam logic [2:0]  c_st_idle      = 3'd0;
    localparam logic [2:0]  c_st_start     = 3'd1;
    localparam logic [2:0]  c_st_data      = 3'd2;
    localparam logic [2:0]  c_st_parity    = 3'd3;
    localparam logic [2:0]  c_st_stop      = 3'd4;
    localparam logic [2:0]  c_st_wait_high = 3'd5;

    // Line rate selected by the 3-bit baud_select code
    function automatic int unsigned uart_baud_rate(input logic [2:0] sel);
        int unsigned rate;
        case (sel)
            3'd0:    rate = 300;
            3'd1:    rate = 1200;
            3'd2:    rate = 4800;
            3'd3:    rate = 9600;
            3'd4:    rate = 19200;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // Clocks per oversample tick: round(clk_hz / (16 * baud)), never below 1
    function automatic int unsigned uart_baud_divisor(input int unsigned clk_hz,
                                                      input logic [2:0]  sel);
        int unsigned den;
        int unsigned div;
        den = c_oversample * uart_baud_rate(sel);
        div = (clk_hz + den / 2) / den;
        if (div == 0) begin
            div = 1;
        end
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_controller.sv
`default_nettype none
//==============================================================================
// Module      : uart_baud_controller
// Description : 16x oversample tick generator. The divisor for baud_select is
//               captured on restart, so a rate change only takes effect at the
//               next restart (i.e. the next frame).
// Ports       : clk, reset      - clock, synchronous active-high reset
//               restart         - clear the divider and capture baud_select
//               baud_select[2:0]- rate code (see uart_pkg::uart_baud_rate)
//               sample_tick     - one-cycle oversample tick
// Revision    : 1.0 - initial release
//==============================================================================
module uart_baud_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [2:0] baud_select,
    output logic       sample_tick
);

    // Width sized for the slowest rate, which has the largest divisor
    localparam int unsigned c_div_w = $clog2(uart_baud_divisor(CLK_HZ, 3'd0) + 1);
    localparam logic [c_div_w-1:0] c_one = c_div_w'(1);

    logic [c_div_w-1:0] r_div;
    logic [c_div_w-1:0] r_cnt;
    logic [c_div_w-1:0] w_div_new;

    assign w_div_new   = c_div_w'(uart_baud_divisor(CLK_HZ, baud_select));
    assign sample_tick = (r_cnt == (r_div - c_one));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= w_div_new;
            r_cnt <= '0;
        end else if (restart) begin
            r_div <= w_div_new;
            r_cnt <= '0;
        end else if (sample_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
//==============================================================================
// Module      : uart_rx_deframer
// Description : UART receiver for 8E1 frames (start, 8 data LSB first, even
//               parity, stop). Line is double-flop synchronised, oversampled
//               16x and each bit sampled at its centre tick.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               Rx_EN            - receiver enable; low aborts and idles
//               RxD              - asynchronous serial input, idle high
//               baud_select[2:0] - rate code, captured at start-bit detection
//               Rx_DATA[7:0]     - data byte of the last completed frame
//               Rx_VALID         - one-cycle pulse, good frame
//               Rx_PERROR        - one-cycle pulse, parity mismatch
//               Rx_FERROR        - one-cycle pulse, stop bit sampled low
// Revision    : 1.0 - initial release
//==============================================================================
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam int unsigned c_tick_w = $clog2(c_oversample);
    localparam logic [c_tick_w-1:0] c_mid_tick = c_tick_w'(c_sample_point - 1);
    localparam logic [c_tick_w-1:0] c_tick_one = c_tick_w'(1);
    localparam logic [2:0]          c_last_bit = 3'd7;

    logic                 r_rxd_meta;
    logic                 r_rxd_sync;
    logic                 w_rxd;
    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic                 w_sample_tick;
    logic                 w_mid;
    logic                 w_restart;
    logic                 w_shift_en;
    logic                 w_parity_en;
    logic                 w_frame_done;
    logic                 w_parity_err;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_parity_bit;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= RxD;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_rxd = r_rxd_sync;

    uart_baud_controller #(
        .CLK_HZ      (CLK_HZ)
    ) u_baud (
        .clk         (clk),
        .reset       (reset),
        .restart     (w_restart),
        .baud_select (baud_select),
        .sample_tick (w_sample_tick)
    );

    // The tick counter is restarted with the divider at the start edge and
    // then wraps every 16 ticks, so the centre of each bit is the 8th tick.
    assign w_mid        = w_sample_tick && (r_tick_cnt == c_mid_tick);
    assign w_parity_err = r_parity_bit ^ (^r_shift);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (!Rx_EN) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_rxd) w_state_next = c_st_start;
                end
                c_st_start: begin
                    if (w_mid) w_state_next = w_rxd ? c_st_idle : c_st_data;
                end
                c_st_data: begin
                    if (w_mid && (r_bit_cnt == c_last_bit)) w_state_next = c_st_parity;
                end
                c_st_parity: begin
                    if (w_mid) w_state_next = c_st_stop;
                end
                c_st_stop: begin
                    if (w_mid) w_state_next = w_rxd ? c_st_idle : c_st_wait_high;
                end
                c_st_wait_high: begin
                    if (w_rxd) w_state_next = c_st_idle;
                end
                default: w_state_next = c_st_idle;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // FSM: output decode (datapath strobes); all gated by Rx_EN so that a
    // disabled receiver neither captures bits nor reports a frame
    //--------------------------------------------------------------------------
    always_comb begin
        w_restart    = 1'b0;
        w_shift_en   = 1'b0;
        w_parity_en  = 1'b0;
        w_frame_done = 1'b0;
        if (Rx_EN) begin
            case (r_state)
                c_st_idle:   w_restart    = !w_rxd;
                c_st_data:   w_shift_en   = w_mid;
                c_st_parity: w_parity_en  = w_mid;
                c_st_stop:   w_frame_done = w_mid;
                default: ;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Datapath: tick/bit counters, shift register, parity capture
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity_bit <= 1'b0;
        end else begin
            if (w_restart) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else begin
                if (w_sample_tick) r_tick_cnt <= r_tick_cnt + c_tick_one;
                if (w_shift_en)    r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            // LSB arrives first, so shift in from the top
            if (w_shift_en)  r_shift      <= {w_rxd, r_shift[7:1]};
            if (w_parity_en) r_parity_bit <= w_rxd;
        end
    end

    // Result registers: loaded on the clock after the stop-bit sample.
    // A low stop bit takes priority over a parity mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            if (w_frame_done) begin
                Rx_DATA   <= r_shift;
                Rx_FERROR <= ~w_rxd;
                Rx_PERROR <= w_rxd & w_parity_err;
                Rx_VALID  <= w_rxd & ~w_parity_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_uart_rx_deframer
// Description : Self-checking bench for uart_rx_deframer. Directed vector
//               table, hand-written corner sequences and random frames judged
//               by a frame-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_rx_deframer;

    // Clock chosen so every divisor is exact and frames stay short
    localparam int unsigned CLK_HZ = 3686400;

    localparam logic [2:0] K_V = 3'b001;
    localparam logic [2:0] K_P = 3'b010;
    localparam logic [2:0] K_F = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       RxD;
    logic [2:0] baud_select;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    always #5 clk = ~clk;

    uart_rx_deframer #(
        .CLK_HZ      (CLK_HZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .baud_select (baud_select),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } event_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [2:0] exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    event_t ev_q[$];
    vec_t   vecs[8];
    int     cyc      = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     t_start  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse with the data byte and cycle it appeared
    always @(negedge clk) begin
        if (Rx_VALID || Rx_PERROR || Rx_FERROR) begin
            ev_q.push_back('{kind: {Rx_FERROR, Rx_PERROR, Rx_VALID}, data: Rx_DATA, cyc: cyc});
        end
    end

    // ---------------- reference model ----------------
    function automatic int bit_cycles(input logic [2:0] sel);
        int rate;
        int div;
        case (sel)
            3'd0: rate = 300;
            3'd1: rate = 1200;
            3'd2: rate = 4800;
            3'd3: rate = 9600;
            3'd4: rate = 19200;
            3'd5: rate = 38400;
            3'd6: rate = 57600;
            default: rate = 115200;
        endcase
        div = (int'(CLK_HZ) + 8 * rate) / (16 * rate);
        return 16 * div;
    endfunction

    function automatic logic [2:0] model_kind(input logic [7:0] d, input logic p, input logic s);
        if (s == 1'b0) return K_F;
        if (($countones({d, p}) % 2) != 0) return K_P;
        return K_V;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [2:0] exp_kind, input logic [7:0] exp_data);
        check({name, " pulse count"}, 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) begin
            check({name, " kind {F,P,V}"}, 32'(ev_q[0].kind), 32'(exp_kind));
            check({name, " pulse data"}, 32'(ev_q[0].data), 32'(exp_data));
        end
        check({name, " Rx_DATA"}, 32'(Rx_DATA), 32'(exp_data));
        ev_q.delete();
    endtask

    task automatic check_none(input string name);
        check({name, " no pulse"}, 32'(ev_q.size()), 32'd0);
        ev_q.delete();
    endtask

    // ---------------- stimulus helpers (always start/end at a negedge) ------
    task automatic drive_bit(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [2:0] sel, input logic [7:0] d, input logic p,
                              input logic s, input logic scramble);
        int bt;
        bt          = bit_cycles(sel);
        baud_select = sel;
        t_start     = cyc;
        RxD         = 1'b0;
        repeat (4) @(negedge clk);
        // The rate is captured at start detection; later changes must not matter
        if (scramble) baud_select = 3'($urandom);
        repeat (bt - 4) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
        drive_bit(p, bt);
        drive_bit(s, bt);
    endtask

    initial begin
        vecs[0] = '{3'd3, 8'hFF, 1'b0, 1'b1, K_V, 8'hFF};
        vecs[1] = '{3'd3, 8'hA5, 1'b1, 1'b1, K_P, 8'hA5};
        vecs[2] = '{3'd7, 8'h00, 1'b0, 1'b1, K_V, 8'h00};
        vecs[3] = '{3'd6, 8'h01, 1'b0, 1'b1, K_P, 8'h01};
        vecs[4] = '{3'd5, 8'h80, 1'b1, 1'b0, K_F, 8'h80};
        vecs[5] = '{3'd4, 8'h7E, 1'b0, 1'b1, K_V, 8'h7E};
        vecs[6] = '{3'd2, 8'hC3, 1'b1, 1'b1, K_P, 8'hC3};
        vecs[7] = '{3'd7, 8'h0F, 1'b1, 1'b0, K_F, 8'h0F};

        reset       = 1'b1;
        Rx_EN       = 1'b1;
        RxD         = 1'b1;
        baud_select = 3'd3;
        repeat (3) @(negedge clk);
        check("reset Rx_DATA",   32'(Rx_DATA),   32'h00);
        check("reset Rx_VALID",  32'(Rx_VALID),  32'h0);
        check("reset Rx_PERROR", 32'(Rx_PERROR), 32'h0);
        check("reset Rx_FERROR", 32'(Rx_FERROR), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        ev_q.delete();

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 8; i++) begin
            int bt;
            bt = bit_cycles(vecs[i].sel);
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop, 1'b0);
            if (i == 0 && ev_q.size() > 0) begin
                int lat;
                int exp_lat;
                lat     = ev_q[0].cyc - t_start;
                exp_lat = bt * 21 / 2;
                n_checks++;
                if (lat < exp_lat - bt / 16 || lat > exp_lat + bt / 16) begin
                    n_errors++;
                    $display("FAIL valid latency: actual=%0d clocks required=%0d+-%0d",
                             lat, exp_lat, bt / 16);
                end
            end
            check_frame($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].exp_data);
            drive_bit(1'b1, bt);
            check_none($sformatf("vec%0d idle", i));
        end

        // ---------------- framing error, line held low, then recovery -------
        begin
            int bt;
            bt = bit_cycles(3'd3);
            send_frame(3'd3, 8'h3C, 1'b0, 1'b0, 1'b0);
            check_frame("ferr 3C", K_F, 8'h3C);
            drive_bit(1'b0, 2 * bt);
            check_none("held low");
            drive_bit(1'b1, bt);
            send_frame(3'd3, 8'h12, 1'b0, 1'b1, 1'b0);
            check_frame("after ferr 12", K_V, 8'h12);
            drive_bit(1'b1, bt);

            // Glitch of 3 oversample ticks: false start
            drive_bit(1'b0, 3 * (bt / 16));
            drive_bit(1'b1, 2 * bt);
            check_none("false start");
            check("false start Rx_DATA", 32'(Rx_DATA), 32'h12);
        end

        // ---------------- reset during data bit 4 ----------------
        begin
            int bt;
            logic [7:0] d;
            bt          = bit_cycles(3'd7);
            d           = 8'hC3;
            baud_select = 3'd7;
            drive_bit(1'b0, bt);
            for (int i = 0; i < 4; i++) drive_bit(d[i], bt);
            drive_bit(d[4], bt / 2);
            reset = 1'b1;
            RxD   = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            drive_bit(1'b1, 2 * bt);
            check_none("reset abort");
            check("reset abort Rx_DATA", 32'(Rx_DATA), 32'h00);
            send_frame(3'd7, 8'h55, 1'b0, 1'b1, 1'b0);
            check_frame("after reset 55", K_V, 8'h55);
            drive_bit(1'b1, bt);
        end

        // ---------------- Rx_EN dropped during parity, then back-to-back ----
        begin
            int bt;
            logic [7:0] d;
            bt          = bit_cycles(3'd7);
            d           = 8'h81;
            baud_select = 3'd7;
            drive_bit(1'b0, bt);
            for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
            drive_bit(1'b0, bt / 2);
            Rx_EN = 1'b0;
            drive_bit(1'b0, bt - bt / 2);
            drive_bit(1'b1, 2 * bt);
            Rx_EN = 1'b1;
            drive_bit(1'b1, bt);
            check_none("enable abort");
            check("enable abort Rx_DATA", 32'(Rx_DATA), 32'h55);
            send_frame(3'd7, 8'h81, 1'b0, 1'b1, 1'b0);
            check_frame("b2b first 81", K_V, 8'h81);
            send_frame(3'd7, 8'h81, 1'b0, 1'b1, 1'b0);
            check_frame("b2b second 81", K_V, 8'h81);
            drive_bit(1'b1, bt);
        end

        // ---------------- random frames against the model ----------------
        for (int n = 0; n < 30; n++) begin
            logic [2:0] sel;
            logic [7:0] d;
            logic       p;
            logic       s;
            int         gap;
            sel = 3'($urandom_range(5, 7));
            d   = 8'($urandom);
            p   = (^d) ^ ($urandom_range(0, 3) == 0);
            s   = ($urandom_range(0, 7) != 0);
            send_frame(sel, d, p, s, 1'b1);
            check_frame($sformatf("rand%0d", n), model_kind(d, p, s), d);
            gap = s ? $urandom_range(0, 1) : 1;
            if (gap > 0) drive_bit(1'b1, gap * bit_cycles(sel));
        end

        drive_bit(1'b1, 64);
        check_none("final idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
